// File: rtl/mem_stage_lsu_pkg.sv
`default_nettype none
// ============================================================================
// Module  : core (package)
// Brief   : Shared LSU types, pipeline context bus and lane-width constants.
// Revision: 1.0 - initial release
// ============================================================================
package core;

  localparam int c_byte_w = 8;
  localparam int c_half_w = 16;
  localparam int c_word_w = 32;

  typedef enum logic [3:0] {
    MEM_NOP = 4'd0,
    MEM_LB  = 4'd1,
    MEM_LH  = 4'd2,
    MEM_LW  = 4'd3,
    MEM_LBU = 4'd4,
    MEM_LHU = 4'd5,
    MEM_SB  = 4'd6,
    MEM_SH  = 4'd7,
    MEM_SW  = 4'd8
  } mem_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } lsu_state_e;

  typedef enum logic [3:0] {
    ALU_NOP = 4'd0,
    ALU_ADD = 4'd1,
    ALU_SUB = 4'd2,
    ALU_AND = 4'd3,
    ALU_OR  = 4'd4
  } alu_op_e;

  typedef enum logic [2:0] {
    NOP = 3'd0,
    FMT_R = 3'd1,
    FMT_I = 3'd2,
    FMT_S = 3'd3,
    FMT_B = 3'd4,
    FMT_U = 3'd5,
    FMT_J = 3'd6
  } format_e;

  typedef enum logic [5:0] {
    I_NOP  = 6'd0,
    I_LOAD = 6'd1,
    I_STORE = 6'd2,
    I_ALU  = 6'd3
  } instr_e;

  typedef struct packed {
    logic [31:0] pc;
    instr_e      instr;
    format_e     format;
    alu_op_e     alu_op;
    mem_op_e     mem_op;
    logic [4:0]  rd;
  } pipeline_bus_t;

  // log2 of the access size in bytes: 0 = byte, 1 = half, 2 = word
  function automatic logic [1:0] mem_size_log2(input mem_op_e op);
    case (op)
      MEM_LH, MEM_LHU, MEM_SH: mem_size_log2 = 2'd1;
      MEM_LW, MEM_SW:          mem_size_log2 = 2'd2;
      default:                 mem_size_log2 = 2'd0;
    endcase
  endfunction

  function automatic logic mem_is_store(input mem_op_e op);
    mem_is_store = (op == MEM_SB) || (op == MEM_SH) || (op == MEM_SW);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_stage_lsu_align.sv
`default_nettype none
// ============================================================================
// Module  : lsu_align
// Brief   : Byte-lane placement of store data/enables and load extract/extend.
// Revision: 1.0 - initial release
// ============================================================================
module lsu_align
  import core::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  mem_op_e                          op,
  input  logic [$clog2(DATA_WIDTH/8)-1:0] lane,
  input  logic [DATA_WIDTH-1:0]            store_data,
  input  logic [DATA_WIDTH-1:0]            rdata,
  output logic [DATA_WIDTH/8-1:0]          be,
  output logic [DATA_WIDTH-1:0]            wdata,
  output logic [DATA_WIDTH-1:0]            load_data
);

  localparam int c_nb     = DATA_WIDTH / 8;
  localparam int c_lane_w = $clog2(c_nb);

  logic [1:0]            w_size;
  logic [c_lane_w-1:0]   w_lane;
  logic [c_lane_w+2:0]   w_shamt;
  logic [DATA_WIDTH-1:0] w_rshift;

  always_comb begin
    w_size = mem_size_log2(op);
    // Lane bits below the access size are dropped so the access aligns down
    w_lane = lane;
    if (w_size != 2'd0) w_lane[0] = 1'b0;
    if (w_size == 2'd2) w_lane[1] = 1'b0;
    w_shamt  = {w_lane, 3'b000};
    w_rshift = rdata >> w_shamt;

    be        = '0;
    wdata     = '0;
    load_data = '0;

    case (w_size)
      2'd0: begin
        be    = c_nb'(1) << w_lane;
        wdata = DATA_WIDTH'(store_data[c_byte_w-1:0]) << w_shamt;
      end
      2'd1: begin
        be    = c_nb'(3) << w_lane;
        wdata = DATA_WIDTH'(store_data[c_half_w-1:0]) << w_shamt;
      end
      default: begin
        be    = c_nb'(15) << w_lane;
        wdata = DATA_WIDTH'(store_data[c_word_w-1:0]) << w_shamt;
      end
    endcase

    if (op == MEM_NOP) be = '0;
    if (!mem_is_store(op)) wdata = '0;

    case (op)
      MEM_LB:  load_data = DATA_WIDTH'($signed(w_rshift[c_byte_w-1:0]));
      MEM_LH:  load_data = DATA_WIDTH'($signed(w_rshift[c_half_w-1:0]));
      MEM_LW:  load_data = DATA_WIDTH'($signed(w_rshift[c_word_w-1:0]));
      MEM_LBU: load_data = DATA_WIDTH'(w_rshift[c_byte_w-1:0]);
      MEM_LHU: load_data = DATA_WIDTH'(w_rshift[c_half_w-1:0]);
      default: load_data = '0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mem_stage_lsu.sv
`default_nettype none
// ============================================================================
// Module  : mem_stage_lsu
// Brief   : Pipeline memory stage, one outstanding dmem access at a time.
//           Define MEM_MISALIGN_TRAP_EN to trap misaligned half/word accesses.
// Revision: 1.0 - initial release
// ============================================================================
module mem_stage_lsu
  import core::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    valid_i,
  input  pipeline_bus_t           bus_i,
  input  mem_op_e                 op_i,
  input  logic [ADDR_WIDTH-1:0]   addr_i,
  input  logic [DATA_WIDTH-1:0]   wdata_i,
  output logic                    ready_o,
  output logic                    valid_o,
  output pipeline_bus_t           mem_bus_o,
  output logic [DATA_WIDTH-1:0]   load_data_o,
  output logic                    misalign_o,
  input  logic                    ready_i,
  output logic                    dmem_req_o,
  output logic                    dmem_we_o,
  output logic [DATA_WIDTH/8-1:0] dmem_be_o,
  output logic [ADDR_WIDTH-1:0]   dmem_addr_o,
  output logic [DATA_WIDTH-1:0]   dmem_wdata_o,
  input  logic                    dmem_gnt_i,
  input  logic                    dmem_rvalid_i,
  input  logic [DATA_WIDTH-1:0]   dmem_rdata_i
);

  localparam int c_lane_w = $clog2(DATA_WIDTH / 8);

  lsu_state_e            r_state;
  mem_op_e               r_op;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  pipeline_bus_t         r_bus;

  logic                  r_valid;
  logic                  r_misalign;
  pipeline_bus_t         r_bus_out;
  logic [DATA_WIDTH-1:0] r_load_data;

  logic                    w_accept;
  logic                    w_misaligned;
  logic [DATA_WIDTH/8-1:0] w_be;
  logic [DATA_WIDTH-1:0]   w_wdata;
  logic [DATA_WIDTH-1:0]   w_load_data;

  assign ready_o  = (r_state == IDLE) && (!r_valid || ready_i);
  assign w_accept = valid_i && ready_o;

`ifdef MEM_MISALIGN_TRAP_EN
  logic [1:0] w_size_in;
  assign w_size_in    = mem_size_log2(op_i);
  assign w_misaligned = ((w_size_in == 2'd1) && addr_i[0]) ||
                        ((w_size_in == 2'd2) && (addr_i[1:0] != 2'b00));
`else
  assign w_misaligned = 1'b0;
`endif

  lsu_align #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_align (
    .op        (r_op),
    .lane      (r_addr[c_lane_w-1:0]),
    .store_data(r_wdata),
    .rdata     (dmem_rdata_i),
    .be        (w_be),
    .wdata     (w_wdata),
    .load_data (w_load_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_op        <= MEM_NOP;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_bus       <= '0;
      r_valid     <= 1'b0;
      r_misalign  <= 1'b0;
      r_bus_out   <= '0;
      r_load_data <= '0;
    end else begin
      if (r_valid && ready_i) r_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            // NOPs and trapped accesses complete without touching dmem
            if ((op_i == MEM_NOP) || w_misaligned) begin
              r_valid     <= 1'b1;
              r_bus_out   <= bus_i;
              r_load_data <= '0;
              r_misalign  <= w_misaligned;
            end else begin
              r_op    <= op_i;
              r_addr  <= addr_i;
              r_wdata <= wdata_i;
              r_bus   <= bus_i;
              r_state <= REQ;
            end
          end
        end
        REQ: begin
          if (dmem_gnt_i) r_state <= WAIT;
        end
        WAIT: begin
          if (dmem_rvalid_i) begin
            r_valid     <= 1'b1;
            r_bus_out   <= r_bus;
            r_load_data <= w_load_data;
            r_misalign  <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign valid_o      = r_valid;
  assign mem_bus_o    = r_bus_out;
  assign load_data_o  = r_load_data;
  assign misalign_o   = r_misalign;

  assign dmem_req_o   = (r_state == REQ);
  assign dmem_we_o    = mem_is_store(r_op);
  assign dmem_be_o    = w_be;
  assign dmem_addr_o  = {r_addr[ADDR_WIDTH-1:c_lane_w], {c_lane_w{1'b0}}};
  assign dmem_wdata_o = w_wdata;

endmodule
`default_nettype wire

// File: tb/tb_mem_stage_lsu.sv
`default_nettype none
// ============================================================================
// Module  : tb_mem_stage_lsu
// Brief   : Directed and random checks of mem_stage_lsu against a byte-level model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_mem_stage_lsu;
  import core::*;

  logic          clk = 1'b0;
  logic          rst;
  logic          valid_i;
  pipeline_bus_t bus_i;
  mem_op_e       op_i;
  logic [31:0]   addr_i;
  logic [31:0]   wdata_i;
  logic          ready_o;
  logic          valid_o;
  pipeline_bus_t mem_bus_o;
  logic [31:0]   load_data_o;
  logic          misalign_o;
  logic          ready_i;
  logic          dmem_req_o;
  logic          dmem_we_o;
  logic [3:0]    dmem_be_o;
  logic [31:0]   dmem_addr_o;
  logic [31:0]   dmem_wdata_o;
  logic          dmem_gnt_i;
  logic          dmem_rvalid_i;
  logic [31:0]   dmem_rdata_i;

  int n_checks = 0;
  int n_fail   = 0;

  mem_stage_lsu #(
    .DATA_WIDTH(32),
    .ADDR_WIDTH(32)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .valid_i      (valid_i),
    .bus_i        (bus_i),
    .op_i         (op_i),
    .addr_i       (addr_i),
    .wdata_i      (wdata_i),
    .ready_o      (ready_o),
    .valid_o      (valid_o),
    .mem_bus_o    (mem_bus_o),
    .load_data_o  (load_data_o),
    .misalign_o   (misalign_o),
    .ready_i      (ready_i),
    .dmem_req_o   (dmem_req_o),
    .dmem_we_o    (dmem_we_o),
    .dmem_be_o    (dmem_be_o),
    .dmem_addr_o  (dmem_addr_o),
    .dmem_wdata_o (dmem_wdata_o),
    .dmem_gnt_i   (dmem_gnt_i),
    .dmem_rvalid_i(dmem_rvalid_i),
    .dmem_rdata_i (dmem_rdata_i)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int op_bytes(input mem_op_e op);
    case (op)
      MEM_LH, MEM_LHU, MEM_SH: return 2;
      MEM_LW, MEM_SW:          return 4;
      default:                 return 1;
    endcase
  endfunction

  // One complete access: issue, service dmem with the given wait states,
  // check the result, then stall the result for 'hold' cycles.
  task automatic run_access(input mem_op_e op, input logic [31:0] addr,
                            input logic [31:0] wd, input logic [31:0] rd,
                            input int gnt_wait, input int rv_wait, input int hold,
                            output logic [31:0] got);
    pipeline_bus_t b;
    int            n, off;
    logic          is_store, is_signed, trap;
    logic [31:0]   wmask, bemask, exp_wdata, exp_load;
    logic [3:0]    exp_be;
    logic [31:0]   s_load;
    logic          s_mis;

    b        = '0;
    b.pc     = $urandom;
    b.rd     = 5'($urandom);
    b.mem_op = op;
    b.instr  = (op == MEM_NOP) ? I_NOP : I_LOAD;
    b.format = FMT_I;
    b.alu_op = ALU_ADD;

    n         = op_bytes(op);
    off       = int'(addr % 4);
    off       = off - (off % n);
    is_store  = (op == MEM_SB) || (op == MEM_SH) || (op == MEM_SW);
    is_signed = (op == MEM_LB) || (op == MEM_LH) || (op == MEM_LW);
    wmask     = (n == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * n)) - 32'd1);
    exp_be    = 4'(((1 << n) - 1) << off);
    for (int i = 0; i < 4; i++) bemask[8*i +: 8] = {8{exp_be[i]}};
    exp_wdata = (wd & wmask) << (8 * off);
    exp_load  = (rd >> (8 * off)) & wmask;
    if (is_signed && exp_load[8*n-1]) exp_load = exp_load | ~wmask;
    if (is_store) exp_load = 32'd0;
`ifdef MEM_MISALIGN_TRAP_EN
    trap = ((n == 2) && (addr % 2 != 0)) || ((n == 4) && (addr % 4 != 0));
`else
    trap = 1'b0;
`endif

    @(negedge clk);
    chk("ready_idle", 64'(ready_o), 64'(1));
    valid_i = 1'b1;
    op_i    = op;
    addr_i  = addr;
    wdata_i = wd;
    bus_i   = b;
    @(negedge clk);
    valid_i = 1'b0;
    op_i    = MEM_NOP;
    addr_i  = $urandom;
    wdata_i = $urandom;
    bus_i   = '0;

    if ((op == MEM_NOP) || trap) begin
      chk("direct_valid", 64'(valid_o), 64'(1));
      chk("direct_load", 64'(load_data_o), 64'(0));
      chk("direct_misalign", 64'(misalign_o), 64'(trap));
      chk("direct_noreq", 64'(dmem_req_o), 64'(0));
    end else begin
      for (int k = 0; k <= gnt_wait; k++) begin
        chk("req_high", 64'(dmem_req_o), 64'(1));
        chk("req_addr", 64'(dmem_addr_o), 64'(addr & 32'hFFFF_FFFC));
        chk("req_we", 64'(dmem_we_o), 64'(is_store));
        chk("req_be", 64'(dmem_be_o), 64'(exp_be));
        if (is_store) chk("req_wdata", 64'(dmem_wdata_o & bemask), 64'(exp_wdata));
        chk("req_ready_low", 64'(ready_o), 64'(0));
        dmem_gnt_i    = (k == gnt_wait);
        dmem_rvalid_i = 1'($urandom);
        dmem_rdata_i  = $urandom;
        @(negedge clk);
      end
      dmem_gnt_i = 1'b0;
      for (int k = 0; k <= rv_wait; k++) begin
        chk("wait_req_low", 64'(dmem_req_o), 64'(0));
        chk("wait_valid_low", 64'(valid_o), 64'(0));
        chk("wait_ready_low", 64'(ready_o), 64'(0));
        dmem_rvalid_i = (k == rv_wait);
        dmem_rdata_i  = (k == rv_wait) ? rd : $urandom;
        dmem_gnt_i    = 1'($urandom);
        @(negedge clk);
      end
      dmem_rvalid_i = 1'b0;
      dmem_gnt_i    = 1'b0;
      chk("resp_valid", 64'(valid_o), 64'(1));
      chk("resp_load", 64'(load_data_o), 64'(exp_load));
      chk("resp_misalign", 64'(misalign_o), 64'(0));
    end
    chk("resp_bus", 64'(mem_bus_o), 64'(b));
    got    = load_data_o;
    s_load = load_data_o;
    s_mis  = misalign_o;

    ready_i = 1'b0;
    for (int k = 0; k < hold; k++) begin
      valid_i = 1'b1;
      op_i    = MEM_LW;
      addr_i  = 32'h0000_0040;
      @(negedge clk);
      chk("hold_valid", 64'(valid_o), 64'(1));
      chk("hold_load", 64'(load_data_o), 64'(s_load));
      chk("hold_bus", 64'(mem_bus_o), 64'(b));
      chk("hold_misalign", 64'(misalign_o), 64'(s_mis));
      chk("hold_ready_low", 64'(ready_o), 64'(0));
      chk("hold_noreq", 64'(dmem_req_o), 64'(0));
    end
    valid_i = 1'b0;
    op_i    = MEM_NOP;
    ready_i = 1'b1;
    @(negedge clk);
    chk("drain_valid_low", 64'(valid_o), 64'(0));
    chk("drain_ready", 64'(ready_o), 64'(1));
  endtask

  initial begin
    logic [31:0] got;
    mem_op_e     ops [9];
    ops = '{MEM_LB, MEM_LH, MEM_LW, MEM_LBU, MEM_LHU, MEM_SB, MEM_SH, MEM_SW, MEM_NOP};

    rst           = 1'b1;
    valid_i       = 1'b0;
    bus_i         = '0;
    op_i          = MEM_NOP;
    addr_i        = '0;
    wdata_i       = '0;
    ready_i       = 1'b1;
    dmem_gnt_i    = 1'b0;
    dmem_rvalid_i = 1'b0;
    dmem_rdata_i  = '0;
    repeat (3) @(negedge clk);

    chk("rst_valid", 64'(valid_o), 64'(0));
    chk("rst_misalign", 64'(misalign_o), 64'(0));
    chk("rst_req", 64'(dmem_req_o), 64'(0));
    chk("rst_load", 64'(load_data_o), 64'(0));
    chk("rst_bus", 64'(mem_bus_o), 64'(0));
    chk("rst_memop", 64'(mem_bus_o.mem_op), 64'(MEM_NOP));
    chk("rst_aluop", 64'(mem_bus_o.alu_op), 64'(ALU_NOP));
    chk("rst_format", 64'(mem_bus_o.format), 64'(NOP));
    chk("rst_instr", 64'(mem_bus_o.instr), 64'(I_NOP));
    rst = 1'b0;

    run_access(MEM_LW, 32'h100, 32'h0, 32'hDEADBEEF, 0, 0, 0, got);
    chk("lw_const", 64'(got), 64'(32'hDEADBEEF));
    run_access(MEM_LB, 32'h103, 32'h0, 32'h80112233, 0, 0, 0, got);
    chk("lb_const", 64'(got), 64'(32'hFFFFFF80));
    run_access(MEM_LBU, 32'h103, 32'h0, 32'h80112233, 1, 2, 0, got);
    chk("lbu_const", 64'(got), 64'(32'h00000080));
    run_access(MEM_SH, 32'h102, 32'h1234, 32'h0, 3, 0, 0, got);
    chk("sh_load_zero", 64'(got), 64'(0));
    run_access(MEM_LW, 32'h200, 32'h0, 32'h12345678, 0, 1, 5, got);
    run_access(MEM_NOP, 32'h300, 32'h0, 32'h0, 0, 0, 1, got);
    run_access(MEM_LW, 32'h102, 32'h0, 32'hCAFEF00D, 0, 0, 0, got);
    run_access(MEM_LH, 32'h106, 32'h0, 32'h8001_7FFF, 2, 0, 0, got);
    chk("lh_const", 64'(got), 64'(32'hFFFF8001));

    // Reset while waiting for rvalid; the late response must be ignored
    @(negedge clk);
    valid_i = 1'b1;
    op_i    = MEM_LW;
    addr_i  = 32'h400;
    @(negedge clk);
    valid_i    = 1'b0;
    op_i       = MEM_NOP;
    dmem_gnt_i = 1'b1;
    @(negedge clk);
    dmem_gnt_i = 1'b0;
    chk("rstw_in_wait", 64'(dmem_req_o), 64'(0));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rstw_valid", 64'(valid_o), 64'(0));
    chk("rstw_ready", 64'(ready_o), 64'(1));
    dmem_rvalid_i = 1'b1;
    dmem_rdata_i  = 32'h5555_AAAA;
    @(negedge clk);
    dmem_rvalid_i = 1'b0;
    chk("rstw_late_valid", 64'(valid_o), 64'(0));
    chk("rstw_late_ready", 64'(ready_o), 64'(1));
    chk("rstw_late_req", 64'(dmem_req_o), 64'(0));

    for (int t = 0; t < 60; t++) begin
      run_access(ops[$urandom_range(0, 8)], $urandom, $urandom, $urandom,
                 int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                 int'($urandom_range(0, 2)), got);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_stage_lsu.md
MEM_STAGE_LSU -- requirements
Module: mem_stage_lsu

Interface
REQ-001 Parameters (name, default, meaning): DATA_WIDTH, 32, memory data width (32 or 64); ADDR_WIDTH, 32, byte address width.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 valid_i  input  1  upstream access valid; bus_i  input  pipeline_bus_t  instruction context; op_i  input  mem_op_e  access type; addr_i  input  ADDR_WIDTH  byte address; wdata_i  input  DATA_WIDTH  store data (low bits used).
REQ-005 ready_o  output  1  stage can accept an access this cycle.
REQ-006 valid_o  output  1  result valid; mem_bus_o  output  pipeline_bus_t  registered context; load_data_o  output  DATA_WIDTH  extended load result; misalign_o  output  1  access trapped as misaligned; ready_i  input  1  downstream accepts.
REQ-007 dmem_req_o  output  1; dmem_we_o  output  1; dmem_be_o  output  DATA_WIDTH/8; dmem_addr_o  output  ADDR_WIDTH (lane-aligned); dmem_wdata_o  output  DATA_WIDTH; dmem_gnt_i  input  1; dmem_rvalid_i  input  1; dmem_rdata_i  input  DATA_WIDTH.

Function
REQ-008 Handshake: transfer when valid_i && ready_o; ready_o = (state==IDLE) && (!valid_o || ready_i); ready_o depends on no other input.
REQ-009 FSM states IDLE, REQ, WAIT, and one output register; at most one memory access outstanding.
REQ-010 IDLE: on accepted MEM_NOP, load output register next edge (valid_o=1, load_data_o=0), stay IDLE, no dmem activity.
REQ-011 IDLE: on accepted load/store, latch op, addr, wdata, bus_i; go to REQ.
REQ-012 REQ: dmem_req_o=1 with stable addr/we/be/wdata until dmem_gnt_i=1; on gnt go to WAIT.
REQ-013 WAIT: dmem_req_o=0; on dmem_rvalid_i=1 (loads and stores) load output register, go to IDLE.
REQ-014 Minimum latency accept->valid_o = 3 cycles (gnt in first REQ cycle, rvalid in first WAIT cycle); unlimited gnt/rvalid wait states tolerated.
REQ-015 Byte lane = addr[log2(DATA_WIDTH/8)-1:0]; SB/SH/SW set 1/2/4 byte enables at the lane, wdata replicated/shifted into lane; loads have we=0, be per width.
REQ-016 LB/LH/LW sign-extend, LBU/LHU zero-extend the lane-extracted data to DATA_WIDTH; stores give load_data_o=0.
REQ-017 valid_o, mem_bus_o, load_data_o, misalign_o hold stable while valid_o && !ready_i.
REQ-018 dmem_rvalid_i outside WAIT and dmem_gnt_i outside REQ are ignored.

Reset
REQ-019 On rst: state IDLE, valid_o=0, misalign_o=0, dmem_req_o=0, load_data_o=0, mem_bus_o zero with mem_op=MEM_NOP, alu_op=ALU_NOP, format=NOP, instr=I_NOP.
REQ-020 Reset mid-access abandons it; a later rvalid for it is ignored per REQ-018.

Configuration
REQ-021 Macro MEM_MISALIGN_TRAP_EN: defined -> halfword at odd address or word not 4-aligned skips REQ/WAIT, loads output register next edge with misalign_o=1, no dmem request.
REQ-022 Not defined -> misalign_o tied 0; low address bits below access size ignored (access aligned down).

Structure
REQ-023 mem_op_e, lsu_state_e and lane-width constants live in package core.
REQ-024 One combinational sub-module lsu_align: byte-enable/wdata lane placement and load extract/extend.

Verification
REQ-025 LW addr 0x100, gnt same cycle, rvalid next, rdata 0xDEADBEEF -> valid_o 3 cycles after accept, load_data_o 0xDEADBEEF.
REQ-026 LB addr 0x103, rdata 0x80112233 -> be 4'b1000, load_data_o 0xFFFFFF80; LBU same -> 0x00000080.
REQ-027 SH addr 0x102, wdata 0x1234, gnt held low 3 cycles -> dmem_req_o 4 cycles, be 4'b1100, dmem_wdata_o[31:16]=0x1234, ready_o=0 throughout.
REQ-028 Result with ready_i=0 for 5 cycles -> outputs stable, ready_o=0, no new dmem_req_o.
REQ-029 With MEM_MISALIGN_TRAP_EN, LW addr 0x102 -> misalign_o=1 next cycle, no dmem_req_o; without, dmem_addr_o 0x100.
REQ-030 rst asserted in WAIT, rvalid arrives after -> valid_o stays 0, state IDLE, ready_o=1.
